// File: rtl/cv32e41s_pkg.sv
// Shared types and constants for the cv32e41s alert escalation logic.
package cv32e41s_pkg;

  localparam int unsigned ALERT_CNT_W   = 8;
  localparam int unsigned ALERT_TIMER_W = 16;

  // The encodings are at least two bits apart, so a single upset always gives an illegal code.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    COUNT = 3'b011,
    MAJOR = 3'b101
  } alert_state_e;

  function automatic logic alert_state_legal(input logic [2:0] s);
    return (s == IDLE) || (s == COUNT) || (s == MAJOR);
  endfunction

endpackage

// File: rtl/cv32e41s_sffs.sv
// Set-type hardened flop: asynchronously sets to 1 on reset.
module cv32e41s_sffs (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_o <= 1'b1;
    else        q_o <= d_i;
  end

endmodule

// File: rtl/cv32e41s_alert_escalator.sv
// Minor/major alert aggregator: a burst of minor alerts inside a sliding window escalates
// to a sticky major alert. The FSM state is guarded by a complemented shadow copy.
module cv32e41s_alert_escalator
  import cv32e41s_pkg::*;
#(
  parameter int unsigned MINOR_THRESHOLD = 4,
  parameter int unsigned WINDOW_CYCLES   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   minor_alert_i,
  input  logic                   major_alert_i,
  output logic                   alert_minor_o,
  output logic                   alert_major_o,
  output logic [ALERT_CNT_W-1:0] minor_cnt_o
);

  if (MINOR_THRESHOLD < 2 || MINOR_THRESHOLD > 255) begin : g_thr_chk
    $error("MINOR_THRESHOLD must be in 2..255");
  end
  if (WINDOW_CYCLES < MINOR_THRESHOLD || WINDOW_CYCLES > 65535) begin : g_win_chk
    $error("WINDOW_CYCLES must be in MINOR_THRESHOLD..65535");
  end

  localparam logic [ALERT_CNT_W-1:0]   THR      = ALERT_CNT_W'(MINOR_THRESHOLD);
  localparam logic [ALERT_TIMER_W-1:0] WIN_LAST = ALERT_TIMER_W'(WINDOW_CYCLES - 1);

  alert_state_e             r_state, w_state_nxt;
  logic [ALERT_CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ALERT_TIMER_W-1:0] r_timer, w_timer_nxt;
  logic                     r_alert_minor, r_alert_major;
  logic [2:0]               w_shadow, w_shadow_d;
  logic                     w_fault;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_fault   = (3'(r_state) != ~w_shadow) || !alert_state_legal(3'(r_state));

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    unique case (r_state)
      IDLE: begin
        if (minor_alert_i) begin
          w_state_nxt = COUNT;
          w_cnt_nxt   = 8'd1;
          w_timer_nxt = WIN_LAST;
        end
      end
      COUNT: begin
        w_timer_nxt = r_timer - 1'b1;
        if (r_timer == '0) begin
          // Window expired: an alert arriving now opens a fresh window.
          if (minor_alert_i) begin
            w_cnt_nxt   = 8'd1;
            w_timer_nxt = WIN_LAST;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
          end
        end else if (minor_alert_i) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == THR) w_state_nxt = MAJOR;
        end
      end
      MAJOR: ;
      default: ;
    endcase
    if (major_alert_i || w_fault) w_state_nxt = MAJOR;
  end

  assign w_shadow_d = ~3'(w_state_nxt);

  for (genvar i = 0; i < 3; i++) begin : g_shadow
    cv32e41s_sffs u_sffs (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (w_shadow_d[i]),
      .q_o   (w_shadow[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_timer       <= '0;
      r_alert_minor <= 1'b0;
      r_alert_major <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timer       <= w_timer_nxt;
      r_alert_minor <= minor_alert_i;
      r_alert_major <= (w_state_nxt == MAJOR);
    end
  end

  assign alert_minor_o = r_alert_minor;
  assign alert_major_o = r_alert_major;
  assign minor_cnt_o   = r_cnt;

endmodule

// File: tb/tb_cv32e41s_alert_escalator.sv
// Self-checking bench for cv32e41s_alert_escalator: vector table, behavioural window model
// and a scoreboard queue of expected outputs.
module tb_cv32e41s_alert_escalator;

  localparam int THR = 4;
  localparam int WIN = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       minor_alert_i;
  logic       major_alert_i;
  logic       alert_minor_o;
  logic       alert_major_o;
  logic [7:0] minor_cnt_o;

  cv32e41s_alert_escalator #(.MINOR_THRESHOLD(THR), .WINDOW_CYCLES(WIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .minor_alert_i (minor_alert_i),
    .major_alert_i (major_alert_i),
    .alert_minor_o (alert_minor_o),
    .alert_major_o (alert_major_o),
    .minor_cnt_o   (minor_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       minor;
    logic       major;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic minor_i;
    logic major_i;
    exp_t exp;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb_q[$];

  // Reference model: tracks the cycle of the window's first alert rather than a countdown.
  typedef enum int {M_IDLE, M_CNT, M_MAJ} mstate_e;
  mstate_e m_st    = M_IDLE;
  int      m_cnt   = 0;
  int      m_start = 0;
  int      m_cyc   = 0;
  logic    m_minor = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_st    = M_IDLE;
    m_cnt   = 0;
    m_minor = 1'b0;
  endfunction

  function automatic void model_step(input logic mn, input logic mj, input logic flt);
    if (mj || flt) m_st = M_MAJ;
    else begin
      case (m_st)
        M_IDLE: if (mn) begin m_st = M_CNT; m_cnt = 1; m_start = m_cyc; end
        M_CNT: begin
          if (m_cyc - m_start >= WIN) begin
            if (mn) begin m_cnt = 1; m_start = m_cyc; end
            else begin m_st = M_IDLE; m_cnt = 0; end
          end else if (mn) begin
            m_cnt++;
            if (m_cnt == THR) m_st = M_MAJ;
          end
        end
        default: ;
      endcase
    end
    m_minor = mn;
    m_cyc++;
  endfunction

  // Called at a falling edge: drive, queue the expectation, then sample at the next falling edge.
  task automatic step(input logic mn, input logic mj, input logic flt,
                      input logic use_tab, input exp_t tab_e);
    exp_t e;
    minor_alert_i = mn;
    major_alert_i = mj;
    model_step(mn, mj, flt);
    e = use_tab ? tab_e : exp_t'{m_minor, (m_st == M_MAJ), 8'(m_cnt)};
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check($sformatf("alert_minor_o@%0d", m_cyc), 32'(alert_minor_o), 32'(e.minor));
    check($sformatf("alert_major_o@%0d", m_cyc), 32'(alert_major_o), 32'(e.major));
    check($sformatf("minor_cnt_o@%0d", m_cyc), 32'(minor_cnt_o), 32'(e.cnt));
  endtask

  task automatic cyc(input logic mn);
    step(mn, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    minor_alert_i = 1'b0;
    major_alert_i = 1'b0;
    #1;
    check({tag, "_rst_major"}, 32'(alert_major_o), 32'd0);
    check({tag, "_rst_minor"}, 32'(alert_minor_o), 32'd0);
    check({tag, "_rst_cnt"}, 32'(minor_cnt_o), 32'd0);
    check({tag, "_rst_shadow"}, 32'(dut.w_shadow), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tab[9];

  initial begin
    tab[0] = '{1'b0, 1'b0, '{1'b0, 1'b0, 8'd0}};
    tab[1] = '{1'b1, 1'b0, '{1'b1, 1'b0, 8'd1}};
    tab[2] = '{1'b0, 1'b0, '{1'b0, 1'b0, 8'd1}};
    tab[3] = '{1'b1, 1'b0, '{1'b1, 1'b0, 8'd2}};
    tab[4] = '{1'b1, 1'b0, '{1'b1, 1'b0, 8'd3}};
    tab[5] = '{1'b0, 1'b0, '{1'b0, 1'b0, 8'd3}};
    tab[6] = '{1'b1, 1'b0, '{1'b1, 1'b1, 8'd4}};
    tab[7] = '{1'b1, 1'b0, '{1'b1, 1'b1, 8'd4}};
    tab[8] = '{1'b0, 1'b1, '{1'b0, 1'b1, 8'd4}};

    rst_n = 1'b0;
    minor_alert_i = 1'b0;
    major_alert_i = 1'b0;
    #12;
    check("por_major", 32'(alert_major_o), 32'd0);
    check("por_cnt", 32'(minor_cnt_o), 32'd0);
    check("por_shadow", 32'(dut.w_shadow), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      step(tab[i].minor_i, tab[i].major_i, 1'b0, 1'b1, tab[i].exp);
    do_reset("tab_major");

    // Four minors at cycles 0,10,20,30: escalation visible after the fourth edge.
    for (int c = 0; c <= 30; c++) begin
      cyc(c % 10 == 0);
      if (c == 29) check("thr_pre_major", 32'(alert_major_o), 32'd0);
    end
    check("thr_major", 32'(alert_major_o), 32'd1);
    check("thr_cnt", 32'(minor_cnt_o), 32'd4);
    do_reset("s1_major");

    // Three minors, then the window lapses back to idle.
    for (int c = 0; c <= 1030; c++) cyc(c == 0 || c == 10 || c == 20);
    check("lapse_cnt", 32'(minor_cnt_o), 32'd0);
    check("lapse_major", 32'(alert_major_o), 32'd0);

    // Last in-window edge counts toward the old window.
    for (int c = 0; c <= 1023; c++) cyc(c == 0 || c == 1023);
    check("win_last_cnt", 32'(minor_cnt_o), 32'd2);
    for (int c = 0; c < 4; c++) cyc(1'b0);
    check("win_last_expire", 32'(minor_cnt_o), 32'd0);

    // Minor exactly on the timer==0 edge starts a new window.
    for (int c = 0; c <= 1024; c++) cyc(c == 0 || c == 1024);
    check("new_win_cnt", 32'(minor_cnt_o), 32'd1);
    check("new_win_major", 32'(alert_major_o), 32'd0);
    for (int c = 0; c < 5; c++) cyc(c == 2);
    check("new_win_cnt2", 32'(minor_cnt_o), 32'd2);
    do_reset("mid_window");

    // Major pulse in COUNT, then a long run of minors: major stays, minor mirrors.
    cyc(1'b1);
    cyc(1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("major_pulse", 32'(alert_major_o), 32'd1);
    for (int c = 0; c < 10000; c++) cyc(c % 7 == 3);
    check("major_sticky", 32'(alert_major_o), 32'd1);
    do_reset("s4_major");

    // Shadow corruption while in COUNT.
    cyc(1'b1);
    check("fault_pre", 32'(alert_major_o), 32'd0);
    force dut.w_shadow = 3'b101;
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    release dut.w_shadow;
    check("fault_major", 32'(alert_major_o), 32'd1);
    cyc(1'b0);
    cyc(1'b1);
    do_reset("fault_major");

    // Fresh threshold run after reset; the first cycle must not raise a fault.
    cyc(1'b0);
    check("post_rst_no_fault", 32'(alert_major_o), 32'd0);
    for (int c = 0; c <= 30; c++) cyc(c % 10 == 0);
    check("rerun_major", 32'(alert_major_o), 32'd1);
    check("rerun_cnt", 32'(minor_cnt_o), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
